rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter AW, default 3: ROM address width.
REQ-002 Parameter DW, default 4: ROM data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 req0_valid  input  1: requester 0 read request.
REQ-007 req0_addr  input  AW: requester 0 read address.
REQ-008 req0_ready  output  1: requester 0 request accepted this cycle.
REQ-009 rsp0_valid  output  1: requester 0 read data valid (one-cycle pulse).
REQ-010 rsp0_data  output  DW: requester 0 read data.
REQ-011 req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data: same directions, widths and meanings as REQ-006 to REQ-010, for requester 1.
REQ-012 rom_addr  output  AW: registered address driven to the combinational ROM (addr port).
REQ-013 rom_data  input  DW: ROM output (out port).
REQ-014 busy  output  1: high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states SHALL be IDLE, READ and RESP.
REQ-016 IDLE, no reqN_valid: SHALL stay in IDLE with all readys at 0.
REQ-017 IDLE, exactly one reqN_valid: SHALL grant that requester.
REQ-018 IDLE, both valid: SHALL grant the requester that is not last_grant (round-robin).
REQ-019 Ready generation: reqN_ready SHALL be combinational, high only in IDLE for the granted requester, and SHALL never be high for both requesters in the same cycle.
REQ-020 Handshake: a handshake is reqN_valid & reqN_ready.
REQ-021 On a handshake, at the next edge: rom_addr <= reqN_addr, owner <= N, last_grant <= N, state -> READ.
REQ-022 READ lasts exactly one cycle. At the edge ending READ: rsp_data register <= rom_data, state -> RESP.
REQ-023 RESP lasts exactly one cycle: rsp<owner>_valid = 1, the other rsp valid = 0, then state -> IDLE.
REQ-024 Latency: a handshake in cycle T SHALL give rsp_valid in cycle T+2. The next handshake is possible in T+3 at the earliest (peak 1 read per 3 cycles).
REQ-025 No readys in READ or RESP; requests arriving then SHALL wait and SHALL not be lost while held valid.
REQ-026 rspN_data SHALL hold the last captured value between responses; only rsp valid qualifies it.
REQ-027 rom_addr SHALL hold its value outside handshake updates (no glitching of ROM address).
REQ-028 Requester dropping valid in IDLE before a handshake: no transaction, last_grant unchanged.
REQ-029 Address wrap: all 2^AW addresses are legal. Address 3'b111 SHALL be handled the same as any other address, with no special case.

Reset
REQ-030 While rst is high: state=IDLE, rom_addr=0, rsp data registers=0, rsp0_valid=rsp1_valid=0, req readys=0, busy=0, owner=0, last_grant=1 (so requester 0 wins the first contention).
REQ-031 Reset asserted in READ or RESP SHALL abort the in-flight read; no rsp_valid for it SHALL appear after reset deasserts.
REQ-032 On the first edge after reset deasserts with requests pending, the block SHALL run normal IDLE arbitration.

Verification
Bench ROM model for all scenarios: rom_data = {1'b1, rom_addr}.
REQ-033 Single read: req0 addr=3'b101 in cycle T -> req0_ready=1 in T; rsp0_valid=1 with rsp0_data=4'hD in T+2; rsp1_valid stays 0.
REQ-034 Contention after reset: both valid, req0 addr=0, req1 addr=7 -> req0 served first (data 4'h8); req1 handshake in T+3, rsp1_data=4'hF in T+5.
REQ-035 Round-robin fairness: both held valid for 12 cycles -> grants alternate 0,1,0,1 and exactly 4 responses occur.
REQ-036 Address sweep: req1 reads addresses 0..7 back-to-back -> rsp1_data = 8..F in order, one response every 3 cycles.
REQ-037 Reset mid-op: rst pulsed during READ of req0 addr=3 -> no rsp0_valid appears; rom_addr=0 and busy=0 immediately (asynchronous).
REQ-038 Protocol checks in every scenario: readys never both 1; rsp valids never both 1; ready never 1 while busy.

Source files
------------

// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter in front of a combinational ROM.
// One read per three cycles: a handshake in IDLE, then READ captures rom_data, then RESP pulses the valid.
//
// Handshake rule, for both requester ports:
//   - A request is taken when reqN_valid and reqN_ready are both high at a rising clk edge.
//   - reqN_ready is combinational and high only in IDLE, only for the granted requester.
//   - A requester keeps reqN_valid and reqN_addr stable until its handshake.
//   - rspN_valid is a one-cycle pulse that cannot be stalled.
//   - rspN_data holds its last captured value between pulses.
module rom_arbiter #(
    parameter int AW = 3,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_data,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_data,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          busy,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_owner;
    logic          r_last_grant;
    logic [AW-1:0] r_rom_addr;
    logic [DW-1:0] r_rsp0_data;
    logic [DW-1:0] r_rsp1_data;
    logic          r_rsp0_valid;
    logic          r_rsp1_valid;

    logic          w_grant0;
    logic          w_grant1;
    logic          w_hs0;
    logic          w_hs1;

    // Under contention the requester that was not served last wins.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = r_last_grant;
                w_grant1 = ~r_last_grant;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign w_hs0 = req0_valid & w_grant0;
    assign w_hs1 = req1_valid & w_grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rom_addr   <= '0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs0) begin
                        r_rom_addr   <= req0_addr;
                        r_owner      <= 1'b0;
                        r_last_grant <= 1'b0;
                        r_state      <= READ;
                    end else if (w_hs1) begin
                        r_rom_addr   <= req1_addr;
                        r_owner      <= 1'b1;
                        r_last_grant <= 1'b1;
                        r_state      <= READ;
                    end
                end
                READ: begin
                    if (r_owner) begin
                        r_rsp1_data <= rom_data;
                    end else begin
                        r_rsp0_data <= rom_data;
                    end
                    r_rsp0_valid <= ~r_owner;
                    r_rsp1_valid <= r_owner;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_data   = r_rsp0_data;
    assign rsp1_data   = r_rsp1_data;
    assign rom_addr    = r_rom_addr;
    assign busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: ROM model rom_data = {1'b1, rom_addr}, a cycle model feeding an
// expected-response queue, an IDLE arbitration vector table and directed multi-cycle sequences.
module tb_rom_arbiter;
    localparam int AW  = 3;
    localparam int DW  = 4;
    localparam int SBW = 1 + DW + 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [DW-1:0] rsp0_data, rsp1_data, rom_data;
    logic [AW-1:0] rom_addr;
    logic [1:0]    dbg_state;

    rom_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / ROM model ----------------
    always #5 clk = ~clk;
    assign rom_data = {1'b1, rom_addr};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] arb(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return last ? 2'b01 : 2'b10;
        return {v1, v0};
    endfunction

    // ---------------- reference model + scoreboard queue ----------------
    logic [SBW-1:0] exp_q[$];
    logic [1:0]     m_cnt;   // 0 idle, 1 read, 2 resp
    logic           m_last;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 2'd0;
            m_last <= 1'b1;
            exp_q.delete();
        end else if (m_cnt == 2'd1) begin
            m_cnt <= 2'd2;
        end else if (m_cnt == 2'd2) begin
            m_cnt <= 2'd0;
        end else begin
            if (arb(req0_valid, req1_valid, m_last) == 2'b01) begin
                m_cnt  <= 2'd1;
                m_last <= 1'b0;
                exp_q.push_back({1'b0, 1'b1, req0_addr, 32'(cyc + 2)});
            end else if (arb(req0_valid, req1_valid, m_last) == 2'b10) begin
                m_cnt  <= 2'd1;
                m_last <= 1'b1;
                exp_q.push_back({1'b1, 1'b1, req1_addr, 32'(cyc + 2)});
            end
        end
    end

    // ---------------- monitor: protocol, model compare, logs ----------------
    int            n_hs0 = 0, n_hs1 = 0, n_rsp0 = 0, n_rsp1 = 0;
    int            hs0_cyc = -1, hs1_cyc = -1, rsp0_cyc = -1, rsp1_cyc = -1;
    logic [DW-1:0] rsp0_dat, rsp1_dat;
    logic [7:0]    hist = '0;
    logic [DW-1:0] sw_dat[$];
    int            sw_cyc[$];

    always @(negedge clk) begin
        logic [1:0]     g;
        logic [SBW-1:0] e;
        if (rst) begin
            check("reset_outputs", {req0_ready, req1_ready, busy, rsp0_valid, rsp1_valid}, 0);
        end else begin
            g = (m_cnt == 2'd0) ? arb(req0_valid, req1_valid, m_last) : 2'b00;
            check("ready0", req0_ready, g[0]);
            check("ready1", req1_ready, g[1]);
            check("busy", busy, m_cnt != 2'd0);
            check("readys_excl", req0_ready & req1_ready, 0);
            check("rsps_excl", rsp0_valid & rsp1_valid, 0);
            check("ready_while_busy", (req0_ready | req1_ready) & busy, 0);
            if (req0_valid && req0_ready) begin
                n_hs0++; hs0_cyc = cyc; hist = {hist[6:0], 1'b0};
            end
            if (req1_valid && req1_ready) begin
                n_hs1++; hs1_cyc = cyc; hist = {hist[6:0], 1'b1};
            end
            if (rsp0_valid) begin
                n_rsp0++; rsp0_cyc = cyc; rsp0_dat = rsp0_data;
            end
            if (rsp1_valid) begin
                n_rsp1++; rsp1_cyc = cyc; rsp1_dat = rsp1_data;
                sw_dat.push_back(rsp1_data); sw_cyc.push_back(cyc);
            end
            if (rsp0_valid || rsp1_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_owner", rsp1_valid, e[SBW-1]);
                    check("sb_data", rsp1_valid ? rsp1_data : rsp0_data, e[SBW-2 -: DW]);
                    check("sb_cycle", cyc, e[31:0]);
                end
            end else if (exp_q.size() != 0 && int'(exp_q[0][31:0]) == cyc) begin
                e = exp_q.pop_front();
                check("missing_rsp", 0, 1);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    // Returns at posedge+1 of the cycle after requester id's handshake.
    task automatic wait_hs(input bit id);
        int start;
        bit seen;
        start = id ? n_hs1 : n_hs0;
        seen  = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); #1;
            if ((id ? n_hs1 : n_hs0) != start) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL hs_timeout%0d: got no handshake in 20 cycles, required one", id);
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic          v1;
        logic [AW-1:0] a1;
        logic          r0;
        logic          r1;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int t, base_hs, base_rsp, base0;
        // valids are dropped before each edge, so last_grant stays at its reset value 1
        vecs[0] = '{1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            vecs[i].a0 = AW'($urandom_range(0, 7));
            vecs[i].a1 = AW'($urandom_range(0, 7));
        end

        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req0_addr = '0; req1_addr = '0;
        repeat (2) step();
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rsp0_data", rsp0_data, 0);
        check("rst_rsp1_data", rsp1_data, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;

        // IDLE arbitration table
        for (int i = 0; i < 5; i++) begin
            step();
            req0_valid = vecs[i].v0; req0_addr = vecs[i].a0;
            req1_valid = vecs[i].v1; req1_addr = vecs[i].a1;
            #1;
            check("tbl_ready0", req0_ready, vecs[i].r0);
            check("tbl_ready1", req1_ready, vecs[i].r1);
            check("tbl_rom_addr", rom_addr, 0);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        step();
        check("tbl_no_txn_busy", busy, 0);

        // single read of requester 0
        base_rsp = n_rsp1;
        step();
        req0_valid = 1'b1; req0_addr = 3'b101; t = cyc;
        #1 check("single_ready0", req0_ready, 1);
        wait_hs(0);
        req0_valid = 1'b0;
        repeat (4) step();
        check("single_hs_cyc", hs0_cyc, t);
        check("single_rsp_cyc", rsp0_cyc, t + 2);
        check("single_rsp_data", rsp0_dat, 4'hD);
        check("single_no_rsp1", n_rsp1, base_rsp);

        // contention pending across reset release
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 3'd0; req1_valid = 1'b1; req1_addr = 3'd7;
        repeat (2) step();
        rst = 1'b0; t = cyc;
        #1 check("cont_first_ready0", req0_ready, 1);
        wait_hs(0);
        req0_valid = 1'b0;
        wait_hs(1);
        req1_valid = 1'b0;
        repeat (4) step();
        check("cont_hs0_cyc", hs0_cyc, t);
        check("cont_rsp0_cyc", rsp0_cyc, t + 2);
        check("cont_rsp0_data", rsp0_dat, 4'h8);
        check("cont_hs1_cyc", hs1_cyc, t + 3);
        check("cont_rsp1_cyc", rsp1_cyc, t + 5);
        check("cont_rsp1_data", rsp1_dat, 4'hF);

        // round-robin: both held for 12 cycles
        base_hs = n_hs0 + n_hs1; base_rsp = n_rsp0 + n_rsp1;
        step();
        req0_valid = 1'b1; req0_addr = AW'($urandom_range(0, 7));
        req1_valid = 1'b1; req1_addr = AW'($urandom_range(0, 7));
        repeat (12) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();
        check("rr_hs_count", n_hs0 + n_hs1 - base_hs, 4);
        check("rr_rsp_count", n_rsp0 + n_rsp1 - base_rsp, 4);
        check("rr_grant_order", hist[3:0], 4'b0101);

        // requester 1 address sweep, back-to-back
        sw_dat.delete(); sw_cyc.delete();
        req1_valid = 1'b1; req1_addr = 3'd0;
        for (int a = 0; a < 8; a++) begin
            wait_hs(1);
            if (a < 7) req1_addr = AW'(a + 1);
            else req1_valid = 1'b0;
        end
        repeat (4) step();
        check("sweep_count", sw_dat.size(), 8);
        for (int i = 0; i < 8 && i < sw_dat.size(); i++) begin
            check("sweep_data", sw_dat[i], 32'(8 + i));
            if (i > 0) check("sweep_spacing", sw_cyc[i] - sw_cyc[i-1], 3);
        end

        // reset during READ of requester 0
        base0 = n_rsp0;
        step();
        req0_valid = 1'b1; req0_addr = 3'd3;
        wait_hs(0);
        req0_valid = 1'b0;
        check("mid_in_read", dbg_state, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rom_addr", rom_addr, 0);
        check("mid_busy", busy, 0);
        check("mid_rsp0_valid", rsp0_valid, 0);
        step();
        rst = 1'b0;
        repeat (6) step();
        check("mid_no_rsp0", n_rsp0, base0);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
